riscv_alu_decode: RTL and testbench
===================================

RISCV_ALU_DECODE -- requirements
Module: riscv_alu_decode

Interface
REQ-001 Parameter: SHAMT_CHECK, default 1, when 1 shift-immediate with instr[25]=1 decodes as illegal.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  instr/rs1_data/rs2_data valid.
REQ-005 in_ready  output  1  stage can accept; registered output.
REQ-006 instr  input  32  RV32I instruction word.
REQ-007 rs1_data  input  32  register-file value for instr[19:15].
REQ-008 rs2_data  input  32  register-file value for instr[24:20].
REQ-009 out_valid  output  1  decoded op presented to ALU.
REQ-010 out_ready  input  1  ALU/downstream accepts op.
REQ-011 alu_ctrl  output  5  ALU operation code, per REQ-015/016.
REQ-012 op_a  output  32  ALU A operand.
REQ-013 op_b  output  32  ALU B operand (register or immediate).
REQ-014 rd  output  5  destination register, instr[11:7]; illegal  output  1  undecodable instruction flag.

Function
REQ-015 Opcode 0110011 (R): f3/f7 000/0000000 ADD=1; 000/0100000 SUB=9; 001 SLL=17; 010 SLT=10; 011 SLTU=12; 100 XOR=5; 101/0000000 SRL=18; 101/0100000 SRA=19; 110 OR=3; 111 AND=7; R-type f7 other than listed -> illegal.
REQ-016 Opcode 0010011 (I): f3 000 ADDI=2; 010 SLTI=11; 011 SLTIU=13; 100 XORI=6; 110 ORI=4; 111 ANDI=8; 001 f7=0000000 SLLI=14; 101 f7=0000000 SRLI=15; 101 f7=0100000 SRAI=16.
REQ-017 Any other opcode/funct combination: alu_ctrl=0, illegal=1, op_a=op_b=0, rd=instr[11:7]; item still flows through handshake.
REQ-018 op_a = rs1_data for all legal ops.
REQ-019 op_b: R-type rs2_data; I-type non-shift sign-extended instr[31:20]; shift-immediate zero-extended instr[24:20].
REQ-020 Latency: accepted item appears on outputs exactly 1 cycle after acceptance when downstream empty.
REQ-021 Storage: two entries, main (drives outputs) and skid; accept = in_valid & in_ready; output transfer = out_valid & out_ready.
REQ-022 Accept with main empty, or main draining same cycle and skid empty -> item loads main.
REQ-023 Accept with main full and not draining -> item loads skid; in_ready deasserts next cycle.
REQ-024 Main draining with skid full -> skid moves to main, skid empties, in_ready reasserts next cycle.
REQ-025 in_ready = !skid_valid (registered); no combinational path in_ready<-out_ready.
REQ-026 While out_valid & !out_ready, alu_ctrl/op_a/op_b/rd/illegal SHALL hold stable.
REQ-027 Order preserved; no item dropped or duplicated; full throughput 1 op/cycle when out_ready held high.
REQ-028 Inputs ignored when in_valid=0 or in_ready=0.

Reset
REQ-029 While rst=1 at clock edge: out_valid=0, skid empty, in_ready=0, alu_ctrl=0, op_a=0, op_b=0, rd=0, illegal=0.
REQ-030 First cycle after rst deasserts: in_ready=1; rst mid-stream discards both entries with no transfer.

Verification
REQ-031 instr=0x002081B3, rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, alu_ctrl=1, op_a=5, op_b=7, rd=3, illegal=0.
REQ-032 instr=0xFFF00293 (ADDI x5,x0,-1), rs1=0 -> alu_ctrl=2, op_b=0xFFFFFFFF, rd=5; instr=0x4043D313 -> alu_ctrl=16, op_b=4, rd=6.
REQ-033 instr=0x402081B3 -> alu_ctrl=9; instr=0x0000A083 (LW) -> illegal=1, alu_ctrl=0, out_valid=1.
REQ-034 out_ready=0, three back-to-back valid inputs -> first held on outputs, second in skid, in_ready=0 after 2nd accept, third not accepted; out_ready=1 -> items emerge in order, in_ready=1 next cycle.
REQ-035 Stream 10 ops with out_ready=1 -> 10 consecutive out_valid cycles, in_ready constant 1.
REQ-036 rst=1 with both entries full -> next cycle out_valid=0, all outputs 0; following cycle in_ready=1.

Source files
------------

// File: rtl/riscv_alu_decode.sv
// RV32I ALU decode stage: turns R-type and I-type ALU instructions into an ALU control
// code plus operands. Results sit in a two-entry (main + skid) valid/ready buffer.
module riscv_alu_decode #(
  parameter bit SHAMT_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  alu_ctrl,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [4:0]  rd,
  output logic        illegal
);

  typedef struct packed {
    logic [4:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
  } entry_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        f7_zero;
  logic        f7_alt;
  logic        sh_zero;
  logic        sh_alt;
  logic        legal;
  logic [4:0]  ctrl;
  logic [31:0] opb;
  entry_t      dec;
  logic        unused_rs1_idx;

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   accept;
  logic   drain;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign funct7  = instr[31:25];
  assign f7_zero = (funct7 == 7'h00);
  assign f7_alt  = (funct7 == 7'h20);
  // With SHAMT_CHECK off, instr[25] is a don't-care (RV64-style 6-bit shamt field).
  assign sh_zero = SHAMT_CHECK ? f7_zero : (funct7[6:1] == 6'h00);
  assign sh_alt  = SHAMT_CHECK ? f7_alt : (funct7[6:1] == 6'h10);
  // The register index is only consumed by the register file upstream.
  assign unused_rs1_idx = ^instr[19:15];

  always_comb begin
    legal = 1'b0;
    ctrl  = '0;
    opb   = '0;
    case (opcode)
      OPC_OP: begin
        opb = rs2_data;
        case (funct3)
          3'b000: begin
            if (f7_zero) begin
              legal = 1'b1;
              ctrl  = 5'd1;
            end else if (f7_alt) begin
              legal = 1'b1;
              ctrl  = 5'd9;
            end
          end
          3'b001: begin legal = f7_zero; ctrl = 5'd17; end
          3'b010: begin legal = f7_zero; ctrl = 5'd10; end
          3'b011: begin legal = f7_zero; ctrl = 5'd12; end
          3'b100: begin legal = f7_zero; ctrl = 5'd5;  end
          3'b101: begin
            if (f7_zero) begin
              legal = 1'b1;
              ctrl  = 5'd18;
            end else if (f7_alt) begin
              legal = 1'b1;
              ctrl  = 5'd19;
            end
          end
          3'b110: begin legal = f7_zero; ctrl = 5'd3; end
          default: begin legal = f7_zero; ctrl = 5'd7; end
        endcase
      end
      OPC_OP_IMM: begin
        opb = {{20{instr[31]}}, instr[31:20]};
        case (funct3)
          3'b000: begin legal = 1'b1; ctrl = 5'd2;  end
          3'b010: begin legal = 1'b1; ctrl = 5'd11; end
          3'b011: begin legal = 1'b1; ctrl = 5'd13; end
          3'b100: begin legal = 1'b1; ctrl = 5'd6;  end
          3'b110: begin legal = 1'b1; ctrl = 5'd4;  end
          3'b001: begin
            opb   = {27'd0, instr[24:20]};
            legal = sh_zero;
            ctrl  = 5'd14;
          end
          3'b101: begin
            opb = {27'd0, instr[24:20]};
            if (sh_zero) begin
              legal = 1'b1;
              ctrl  = 5'd15;
            end else if (sh_alt) begin
              legal = 1'b1;
              ctrl  = 5'd16;
            end
          end
          default: begin legal = 1'b1; ctrl = 5'd8; end
        endcase
      end
      default: ;
    endcase
  end

  // Illegal items still flow through the buffer, but carry only rd and the flag.
  always_comb begin
    dec    = '0;
    dec.rd = instr[11:7];
    if (legal) begin
      dec.ctrl = ctrl;
      dec.a    = rs1_data;
      dec.b    = opb;
    end else begin
      dec.ill = 1'b1;
    end
  end

  assign accept = in_valid & in_ready_q;
  assign drain  = main_valid_q & out_ready;

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (!main_valid_q || drain) begin
      // in_ready is low whenever skid is full, so accept and skid refill never coincide.
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign alu_ctrl  = main_q.ctrl;
  assign op_a      = main_q.a;
  assign op_b      = main_q.b;
  assign rd        = main_q.rd;
  assign illegal   = main_q.ill;

endmodule

// File: tb/tb_riscv_alu_decode.sv
// Scoreboard bench for riscv_alu_decode: directed instruction vectors, a monitor that pops
// expected results on every output transfer, plus handshake, back-pressure and reset scenarios.
module tb_riscv_alu_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd;
  logic        illegal;

  always #5 clk = ~clk;

  riscv_alu_decode #(.SHAMT_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_ctrl(alu_ctrl),
    .op_a(op_a), .op_b(op_b), .rd(rd), .illegal(illegal)
  );

  typedef struct {
    logic [4:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  exp_t snap;
  logic snap_ok = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   s_hi, s_first, s_last, s_rdy_lo, guard_cnt;

  localparam logic [31:0] RA = 32'hA5A5_0001;
  localparam logic [31:0] RB = 32'h0000_0013;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endfunction

  function automatic exp_t mk(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] r, input logic ill);
    exp_t e;
    e.ctrl = c; e.a = a; e.b = b; e.rd = r; e.ill = ill;
    return e;
  endfunction

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] r);
    return {f7, 5'd2, 5'd1, f3, r, 7'b0110011};
  endfunction

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] r);
    return {imm, 5'd1, f3, r, 7'b0010011};
  endfunction

  // Called half-way into a cycle; holds the item until accepted, then records its expectation.
  task automatic send(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    int guard = 0;
    in_valid = 1'b1; instr = i; rs1_data = a; rs2_data = b;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #2;
      guard++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
    end else begin
      exp_q.push_back(e);
    end
    @(posedge clk); #2;
    in_valid = 1'b0; instr = 32'hDEAD_BEEF; rs1_data = 32'h1234_5678; rs2_data = 32'h8765_4321;
  endtask

  task automatic vec(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] c, input logic [31:0] ea, input logic [31:0] eb,
                     input logic [4:0] erd, input logic eill);
    send(i, a, b, mk(c, ea, eb, erd, eill));
  endtask

  // Monitor: pops on every transfer, and checks outputs hold while stalled.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        snap_ok = 1'b0;
      end else begin
        if (out_valid && snap_ok) begin
          chk("hold_alu_ctrl", alu_ctrl, snap.ctrl);
          chk("hold_op_a", op_a, snap.a);
          chk("hold_op_b", op_b, snap.b);
          chk("hold_rd", rd, snap.rd);
          chk("hold_illegal", illegal, snap.ill);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output alu_ctrl=%0d rd=%0d required=no_output", alu_ctrl, rd);
          end else begin
            mon_e = exp_q.pop_front();
            chk("alu_ctrl", alu_ctrl, mon_e.ctrl);
            chk("op_a", op_a, mon_e.a);
            chk("op_b", op_b, mon_e.b);
            chk("rd", rd, mon_e.rd);
            chk("illegal", illegal, mon_e.ill);
            $display("txn ctrl=%0d op_a=%08h op_b=%08h rd=%0d illegal=%0b", alu_ctrl, op_a, op_b, rd, illegal);
          end
          snap_ok = 1'b0;
        end else if (out_valid) begin
          snap = mk(alu_ctrl, op_a, op_b, rd, illegal);
          snap_ok = 1'b1;
        end else begin
          snap_ok = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr = '0; rs1_data = '0; rs2_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    chk("rst_op_a", op_a, 0);
    chk("rst_op_b", op_b, 0);
    chk("rst_rd", rd, 0);
    chk("rst_illegal", illegal, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
    chk("in_ready_after_reset", in_ready, 1);

    // Directed decode vectors, streamed back-to-back with downstream always ready.
    out_ready = 1'b1;
    vec(32'h002081B3, 32'd5, 32'd7, 5'd1, 32'd5, 32'd7, 5'd3, 1'b0);
    vec(32'hFFF00293, 32'd0, RB, 5'd2, 32'd0, 32'hFFFF_FFFF, 5'd5, 1'b0);
    vec(32'h4043D313, 32'h8000_0000, RB, 5'd16, 32'h8000_0000, 32'd4, 5'd6, 1'b0);
    vec(32'h402081B3, 32'd10, 32'd3, 5'd9, 32'd10, 32'd3, 5'd3, 1'b0);
    vec(32'h0000A083, 32'd1, 32'd2, 5'd0, 32'd0, 32'd0, 5'd1, 1'b1);
    vec(rtype(7'h00, 3'd1, 5'd4), RA, RB, 5'd17, RA, RB, 5'd4, 1'b0);
    vec(rtype(7'h00, 3'd2, 5'd5), RA, RB, 5'd10, RA, RB, 5'd5, 1'b0);
    vec(rtype(7'h00, 3'd3, 5'd6), RA, RB, 5'd12, RA, RB, 5'd6, 1'b0);
    vec(rtype(7'h00, 3'd4, 5'd7), RA, RB, 5'd5, RA, RB, 5'd7, 1'b0);
    vec(rtype(7'h00, 3'd5, 5'd8), RA, RB, 5'd18, RA, RB, 5'd8, 1'b0);
    vec(rtype(7'h20, 3'd5, 5'd9), RA, RB, 5'd19, RA, RB, 5'd9, 1'b0);
    vec(rtype(7'h00, 3'd6, 5'd10), RA, RB, 5'd3, RA, RB, 5'd10, 1'b0);
    vec(rtype(7'h00, 3'd7, 5'd11), RA, RB, 5'd7, RA, RB, 5'd11, 1'b0);
    vec(rtype(7'h01, 3'd0, 5'd12), RA, RB, 5'd0, 32'd0, 32'd0, 5'd12, 1'b1);
    vec(rtype(7'h20, 3'd7, 5'd13), RA, RB, 5'd0, 32'd0, 32'd0, 5'd13, 1'b1);
    vec(itype(12'h800, 3'd2, 5'd14), RA, RB, 5'd11, RA, 32'hFFFF_F800, 5'd14, 1'b0);
    vec(itype(12'h7FF, 3'd3, 5'd15), RA, RB, 5'd13, RA, 32'h0000_07FF, 5'd15, 1'b0);
    vec(itype(12'h0F0, 3'd4, 5'd16), RA, RB, 5'd6, RA, 32'h0000_00F0, 5'd16, 1'b0);
    vec(itype(12'hABC, 3'd6, 5'd17), RA, RB, 5'd4, RA, 32'hFFFF_FABC, 5'd17, 1'b0);
    vec(itype(12'h0F0, 3'd7, 5'd18), RA, RB, 5'd8, RA, 32'h0000_00F0, 5'd18, 1'b0);
    vec(itype(12'h01F, 3'd1, 5'd19), RA, RB, 5'd14, RA, 32'd31, 5'd19, 1'b0);
    vec(itype(12'h023, 3'd1, 5'd20), RA, RB, 5'd0, 32'd0, 32'd0, 5'd20, 1'b1);
    vec(itype(12'h001, 3'd5, 5'd21), RA, RB, 5'd15, RA, 32'd1, 5'd21, 1'b0);
    vec(itype(12'h41F, 3'd5, 5'd22), RA, RB, 5'd16, RA, 32'd31, 5'd22, 1'b0);
    vec(itype(12'h200, 3'd5, 5'd23), RA, RB, 5'd0, 32'd0, 32'd0, 5'd23, 1'b1);
    vec(32'h12345037, RA, RB, 5'd0, 32'd0, 32'd0, 5'd0, 1'b1);
    repeat (3) @(posedge clk);
    #2;

    // Ten-op stream: expect ten consecutive out_valid cycles and in_ready never dropping.
    s_hi = 0; s_first = -1; s_last = -1; s_rdy_lo = 0;
    fork
      begin
        for (int k = 0; k < 10; k++)
          vec(itype(12'(k), 3'd0, 5'(k + 1)), 32'(k * 3), RB, 5'd2, 32'(k * 3), 32'(k), 5'(k + 1), 1'b0);
      end
      begin
        for (int n = 0; n < 13; n++) begin
          @(negedge clk);
          if (out_valid) begin
            s_hi++;
            if (s_first < 0) s_first = n;
            s_last = n;
          end
          if (!in_ready) s_rdy_lo++;
        end
      end
    join
    chk("stream_valid_cycles", s_hi, 10);
    chk("stream_contiguous", s_last - s_first + 1, 10);
    chk("stream_in_ready_low_cycles", s_rdy_lo, 0);
    @(posedge clk); #2;

    // Back-pressure: first item held, second in skid, third refused.
    out_ready = 1'b0;
    vec(rtype(7'h00, 3'd4, 5'd24), 32'h0000_00FF, 32'h0000_0F0F, 5'd5, 32'h0000_00FF, 32'h0000_0F0F, 5'd24, 1'b0);
    vec(itype(12'h005, 3'd0, 5'd25), 32'd100, RB, 5'd2, 32'd100, 32'd5, 5'd25, 1'b0);
    chk("in_ready_after_2nd_accept", in_ready, 0);
    chk("held_out_valid", out_valid, 1);
    chk("held_first_rd", rd, 24);
    in_valid = 1'b1; instr = rtype(7'h20, 3'd0, 5'd26); rs1_data = 32'd9; rs2_data = 32'd4;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      chk("third_refused_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #2;
    chk("in_ready_reassert", in_ready, 1);
    chk("skid_to_main_valid", out_valid, 1);
    vec(rtype(7'h20, 3'd0, 5'd26), 32'd9, 32'd4, 5'd9, 32'd9, 32'd4, 5'd26, 1'b0);
    repeat (3) @(posedge clk);
    #2;

    // Reset with both entries full discards them without any transfer.
    out_ready = 1'b0;
    vec(rtype(7'h00, 3'd6, 5'd27), RA, RB, 5'd3, RA, RB, 5'd27, 1'b0);
    vec(itype(12'hFFF, 3'd7, 5'd28), RA, RB, 5'd8, RA, 32'hFFFF_FFFF, 5'd28, 1'b0);
    rst = 1'b1;
    @(posedge clk); #2;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_alu_ctrl", alu_ctrl, 0);
    chk("midrst_op_a", op_a, 0);
    chk("midrst_op_b", op_b, 0);
    chk("midrst_rd", rd, 0);
    chk("midrst_illegal", illegal, 0);
    chk("midrst_in_ready", in_ready, 0);
    exp_q.delete();
    rst = 1'b0;
    @(posedge clk); #2;
    chk("post_midrst_in_ready", in_ready, 1);
    chk("post_midrst_out_valid", out_valid, 0);
    out_ready = 1'b1;
    vec(32'h002081B3, 32'd5, 32'd7, 5'd1, 32'd5, 32'd7, 5'd3, 1'b0);

    guard_cnt = 0;
    while (exp_q.size() != 0 && guard_cnt < 100) begin
      @(posedge clk);
      guard_cnt++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_pending actual=%0d required=0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
